// File: rtl/tlul_host_arb.sv
// tlul_host_arb: shares one TL-UL host port between NumHosts upstream hosts with
// round-robin A arbitration, in-order response steering and a response timeout.
// Revision: 1.0
`default_nettype none

package tlul_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module tlul_host_arb #(
  parameter int unsigned NumHosts       = 3,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned TimeoutCycles  = 255
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  tlul_pkg::tl_h2d_t                    tl_h_i [NumHosts],
  output tlul_pkg::tl_d2h_t                    tl_h_o [NumHosts],
  output tlul_pkg::tl_h2d_t                    tl_d_o,
  input  tlul_pkg::tl_d2h_t                    tl_d_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic                                 timeout_o,
  output logic                                 unexp_rsp_o
);

  localparam int unsigned IDXW = $clog2(NumHosts);
  localparam int unsigned PTRW = $clog2(MaxOutstanding);
  localparam int unsigned CNTW = $clog2(MaxOutstanding + 1);
  localparam int unsigned TOW  = $clog2(TimeoutCycles + 1);

  localparam logic [CNTW-1:0] C_CNT_FULL = CNTW'(MaxOutstanding);
  localparam logic [TOW-1:0]  C_TO_MAX   = TOW'(TimeoutCycles);
  localparam logic [IDXW-1:0] C_IDX_LAST = IDXW'(NumHosts - 1);

  logic [IDXW-1:0] rr_q, rr_d;
  logic            lock_q, lock_d;
  logic [IDXW-1:0] lock_idx_q, lock_idx_d;
  logic [PTRW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [IDXW-1:0] mem_q [MaxOutstanding];
  logic [IDXW-1:0] mem_d [MaxOutstanding];
  logic [TOW-1:0]  tcnt_q, tcnt_d;
  logic            unexp_q, unexp_d;

  logic            fifo_empty, fifo_full;
  logic [IDXW-1:0] head_idx;
  logic            d_hs, a_hs;
  logic            arb_found;
  logic [IDXW-1:0] arb_idx;
  logic            gnt_vld;
  logic [IDXW-1:0] gnt_idx;
  logic            fwd_valid;

  assign fifo_empty = (cnt_q == '0);
  assign head_idx   = mem_q[rptr_q];
  assign d_hs       = !fifo_empty && tl_d_i.d_valid && tl_h_i[head_idx].d_ready;
  // A full FIFO can still take a push when the head retires in the same cycle.
  assign fifo_full  = (cnt_q == C_CNT_FULL) && !d_hs;

  always_comb begin
    int unsigned c;
    c         = 0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int unsigned i = 0; i < NumHosts; i++) begin
      c = int'(rr_q) + i;
      if (c >= NumHosts) c = c - NumHosts;
      if (!arb_found && tl_h_i[c].a_valid) begin
        arb_found = 1'b1;
        arb_idx   = IDXW'(c);
      end
    end
  end

  assign gnt_vld   = lock_q || arb_found;
  assign gnt_idx   = lock_q ? lock_idx_q : arb_idx;
  // Reset gating keeps hosts from seeing a_ready while bookkeeping is being cleared.
  assign fwd_valid = rst_ni && gnt_vld && tl_h_i[gnt_idx].a_valid && !fifo_full;
  assign a_hs      = fwd_valid && tl_d_i.a_ready;

  always_comb begin
    tl_d_o         = tl_h_i[gnt_idx];
    tl_d_o.a_valid = fwd_valid;
    tl_d_o.d_ready = fifo_empty ? 1'b1 : tl_h_i[head_idx].d_ready;
  end

  for (genvar g = 0; g < NumHosts; g++) begin : g_host
    always_comb begin
      tl_h_o[g]         = tl_d_i;
      tl_h_o[g].a_ready = rst_ni && gnt_vld && !fifo_full && tl_d_i.a_ready &&
                          (gnt_idx == IDXW'(g));
      tl_h_o[g].d_valid = !fifo_empty && tl_d_i.d_valid && (head_idx == IDXW'(g));
    end
  end

  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    mem_d      = mem_q;
    if (a_hs) begin
      rr_d           = (gnt_idx == C_IDX_LAST) ? '0 : gnt_idx + 1'b1;
      lock_d         = 1'b0;
      mem_d[wptr_q]  = gnt_idx;
    end else if (fwd_valid) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt_idx;
    end
    wptr_d = wptr_q + PTRW'(a_hs);
    rptr_d = rptr_q + PTRW'(d_hs);
    cnt_d  = cnt_q + CNTW'(a_hs) - CNTW'(d_hs);

    tcnt_d = tcnt_q;
    if (d_hs || fifo_empty) begin
      tcnt_d = '0;
    end else if (tcnt_q != C_TO_MAX) begin
      tcnt_d = tcnt_q + 1'b1;
    end
    unexp_d = tl_d_i.d_valid && fifo_empty;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      tcnt_q     <= '0;
      unexp_q    <= 1'b0;
      for (int i = 0; i < MaxOutstanding; i++) mem_q[i] <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      tcnt_q     <= tcnt_d;
      unexp_q    <= unexp_d;
      mem_q      <= mem_d;
    end
  end

  assign outstanding_o = cnt_q;
  assign timeout_o     = (tcnt_q == C_TO_MAX);
  assign unexp_rsp_o   = unexp_q;

endmodule

`default_nettype wire

// File: tb/tb_tlul_host_arb.sv
// tb_tlul_host_arb: randomized TL-UL traffic checked against a queue-based model
// of the arbiter, response steering, timeout and unexpected-response rules.
`default_nettype none

module tb_tlul_host_arb;

  localparam int N = 3;
  localparam int M = 4;
  localparam int T = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  tlul_pkg::tl_h2d_t h_i [N];
  tlul_pkg::tl_d2h_t h_o [N];
  tlul_pkg::tl_h2d_t d_o;
  tlul_pkg::tl_d2h_t d_i;
  logic [2:0]        outst;
  logic              tmo;
  logic              unexp;

  tlul_host_arb #(.NumHosts(N), .MaxOutstanding(M), .TimeoutCycles(T)) dut (
    .clk_i(clk), .rst_ni(rst_n), .tl_h_i(h_i), .tl_h_o(h_o), .tl_d_o(d_o),
    .tl_d_i(d_i), .outstanding_o(outst), .timeout_o(tmo), .unexp_rsp_o(unexp)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: accepted-request order as a queue of host ids.
  int q[$];
  int rr_m, lock_m, lock_h, tcnt_m;
  bit unexp_m;
  bit          pend [N];
  logic [31:0] addr [N];
  logic [31:0] data [N];

  task automatic model_reset();
    q.delete();
    rr_m = 0; lock_m = 0; lock_h = 0; tcnt_m = 0; unexp_m = 0;
    for (int i = 0; i < N; i++) pend[i] = 0;
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic cycle(input int p_req, input int p_ard, input int p_dv);
    bit empty, pop, full, fwd, hs;
    int head, gnt;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && $urandom_range(99) < p_req) begin
        pend[i] = 1;
        addr[i] = {i[7:0], 24'($urandom)};
        data[i] = $urandom;
      end
      h_i[i]           = '0;
      h_i[i].a_valid   = pend[i];
      h_i[i].a_address = addr[i];
      h_i[i].a_data    = data[i];
      h_i[i].a_source  = 8'(i);
      h_i[i].d_ready   = ($urandom_range(99) < 70);
    end
    d_i         = '0;
    d_i.a_ready = ($urandom_range(99) < p_ard);
    d_i.d_valid = (q.size() > 0) ? ($urandom_range(99) < p_dv) : ($urandom_range(99) < 3);
    d_i.d_data  = $urandom;
    #1;
    empty = (q.size() == 0);
    head  = empty ? -1 : q[0];
    pop   = !empty && d_i.d_valid && h_i[head].d_ready;
    full  = (q.size() == M) && !pop;
    gnt   = -1;
    if (lock_m != 0) gnt = lock_h;
    else begin
      for (int k = 0; k < N; k++) begin
        if (gnt < 0 && pend[(rr_m + k) % N]) gnt = (rr_m + k) % N;
      end
    end
    fwd = (gnt >= 0) && pend[gnt] && !full;
    hs  = fwd && d_i.a_ready;

    check_eq("ds_a_valid", d_o.a_valid, fwd);
    if (fwd) begin
      check_eq("ds_a_address", d_o.a_address, addr[gnt]);
      check_eq("ds_a_data", d_o.a_data, data[gnt]);
    end
    check_eq("ds_d_ready", d_o.d_ready, empty ? 1'b1 : h_i[head].d_ready);
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("a_ready%0d", i), h_o[i].a_ready, (gnt == i) && !full && d_i.a_ready);
      check_eq($sformatf("d_valid%0d", i), h_o[i].d_valid, (head == i) && d_i.d_valid);
      if (head == i && d_i.d_valid) check_eq($sformatf("d_data%0d", i), h_o[i].d_data, d_i.d_data);
    end
    check_eq("outstanding", outst, q.size());
    check_eq("timeout", tmo, tcnt_m == T);
    check_eq("unexp_rsp", unexp, unexp_m);

    @(posedge clk);
    tcnt_m  = (pop || empty) ? 0 : ((tcnt_m < T) ? tcnt_m + 1 : T);
    unexp_m = d_i.d_valid && empty;
    if (pop) void'(q.pop_front());
    if (hs) begin
      q.push_back(gnt);
      rr_m = (gnt + 1) % N;
      lock_m = 0;
      pend[gnt] = 0;
    end else if (fwd) begin
      lock_m = 1;
      lock_h = gnt;
    end
    #1;
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_outstanding", outst, 0);
    check_eq("rst_timeout", tmo, 0);
    check_eq("rst_unexp", unexp, 0);
    check_eq("rst_ds_a_valid", d_o.a_valid, 0);
    for (int i = 0; i < N; i++) check_eq($sformatf("rst_a_ready%0d", i), h_o[i].a_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      h_i[i] = '0;
      addr[i] = '0;
      data[i] = '0;
    end
    d_i = '0;
    d_i.a_ready = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    check_eq("init_outstanding", outst, 0);
    check_eq("init_timeout", tmo, 0);
    check_eq("init_unexp", unexp, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int ph = 0; ph < 12; ph++) begin
      if (ph == 6) mid_reset();
      for (int c = 0; c < 250; c++) begin
        case (ph % 4)
          0: cycle(80, 70, 60);
          1: cycle(90, 80, 0);
          2: cycle(80, 15, 60);
          default: cycle($urandom_range(100), $urandom_range(100), $urandom_range(100));
        endcase
        // Burst a mid-transfer reset once traffic is in flight.
        if (ph == 9 && c == 120) mid_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
